// File: rtl/irq_ctrl.sv
// irq_ctrl: single-level interrupt controller sitting between the timer unit
// and the fetch stage. Rising edges on each source set a pending bit; when
// interrupts are enabled the highest-priority pending source is latched and
// a redirect to its vector is requested. The handler returns via mret,
// which redirects fetch back to the saved epc and restores the enable.
//
// Build option: define IRQ_CTRL_EXT_SRC_EN to add the ext_irq source
// (lower priority than the timer, vector IRQ_VECTOR_EXT, cause 2'b10).
// With the macro undefined, only the timer source exists.
//
// All outputs are registered; the FSM state and its outputs update together.
module irq_ctrl #(
    parameter logic [31:0] IRQ_VECTOR_TIMER = 32'h00000100
`ifdef IRQ_CTRL_EXT_SRC_EN
    ,
    parameter logic [31:0] IRQ_VECTOR_EXT   = 32'h00000180
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_interrupt,
`ifdef IRQ_CTRL_EXT_SRC_EN
    input  logic        ext_irq,
`endif
    input  logic        ie_we,
    input  logic        ie_wdata,
    input  logic [31:0] current_pc,
    input  logic        irq_ack,
    input  logic        mret,
    input  logic        ovr_clr,
    output logic        irq_req,
    output logic [31:0] irq_target,
    output logic        ret_redirect,
    output logic [31:0] epc,
    output logic [1:0]  irq_cause,
    output logic        in_handler,
    output logic        ie,
    output logic        irq_overrun
);

`ifdef IRQ_CTRL_EXT_SRC_EN
    localparam int NSRC = 2;
`else
    localparam int NSRC = 1;
`endif

    // Cause encodings double as the latched-source identifier.
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_TIMER = 2'b01;
`ifdef IRQ_CTRL_EXT_SRC_EN
    localparam logic [1:0] CAUSE_EXT   = 2'b10;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } state_t;

    // Source vector: bit 0 is the timer, bit 1 (if present) is external.
    logic [NSRC-1:0] src;
    logic [NSRC-1:0] src_prev_q, src_prev_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] ack_mask;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  pick_cause;
    logic [31:0] pick_vec;

    logic        irq_req_q, irq_req_d;
    logic [31:0] irq_target_q, irq_target_d;
    logic        ret_q, ret_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        in_handler_q, in_handler_d;
    logic        ie_q, ie_d;
    logic        pie_q, pie_d;
    logic        ovr_q, ovr_d;

    // Gather sources; priority pick and ack-clear mask depend on build.
    always_comb begin
`ifdef IRQ_CTRL_EXT_SRC_EN
        src        = {ext_irq, timer_interrupt};
        pick_cause = pending_q[0] ? CAUSE_TIMER : CAUSE_EXT;
        pick_vec   = pending_q[0] ? IRQ_VECTOR_TIMER : IRQ_VECTOR_EXT;
        ack_mask   = {sel_q == CAUSE_EXT, sel_q == CAUSE_TIMER};
`else
        src        = timer_interrupt;
        pick_cause = CAUSE_TIMER;
        pick_vec   = IRQ_VECTOR_TIMER;
        ack_mask   = 1'b1;
`endif
    end

    // Next-state logic: edge detect, pending/overrun bookkeeping, FSM.
    always_comb begin
        edge_det     = src & ~src_prev_q;
        src_prev_d   = src;
        state_d      = state_q;
        sel_d        = sel_q;
        irq_req_d    = irq_req_q;
        irq_target_d = irq_target_q;
        ret_d        = 1'b0;
        epc_d        = epc_q;
        cause_d      = cause_q;
        in_handler_d = in_handler_q;
        ie_d         = ie_we ? ie_wdata : ie_q;
        pie_d        = pie_q;
        clr_mask     = '0;

        unique case (state_q)
            IDLE: begin
                if (ie_q && (|pending_q)) begin
                    state_d      = REQ;
                    sel_d        = pick_cause;
                    irq_req_d    = 1'b1;
                    irq_target_d = pick_vec;
                end
            end
            REQ: begin
                // Request stays up regardless of ie until fetch accepts it.
                if (irq_ack) begin
                    state_d      = HANDLER;
                    epc_d        = current_pc;
                    cause_d      = sel_q;
                    clr_mask     = ack_mask;
                    pie_d        = ie_q;
                    ie_d         = 1'b0;
                    in_handler_d = 1'b1;
                    irq_req_d    = 1'b0;
                    irq_target_d = 32'h0;
                end
            end
            HANDLER: begin
                if (mret) begin
                    state_d      = RET;
                    ret_d        = 1'b1;
                    irq_target_d = epc_q;
                    in_handler_d = 1'b0;
                end
            end
            RET: begin
                state_d      = IDLE;
                irq_target_d = 32'h0;
                ie_d         = pie_q;
                cause_d      = CAUSE_NONE;
            end
            default: state_d = IDLE;
        endcase

        // A new edge beats the ack-clear so it is never lost.
        pending_d = (pending_q & ~clr_mask) | edge_det;
        // Overrun is sticky; a fresh overrun beats a same-cycle clear.
        ovr_d     = (ovr_q & ~ovr_clr) | (|(edge_det & pending_q));
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= CAUSE_NONE;
            src_prev_q   <= '0;
            pending_q    <= '0;
            irq_req_q    <= 1'b0;
            irq_target_q <= 32'h0;
            ret_q        <= 1'b0;
            epc_q        <= 32'h0;
            cause_q      <= CAUSE_NONE;
            in_handler_q <= 1'b0;
            ie_q         <= 1'b0;
            pie_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            src_prev_q   <= src_prev_d;
            pending_q    <= pending_d;
            irq_req_q    <= irq_req_d;
            irq_target_q <= irq_target_d;
            ret_q        <= ret_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            in_handler_q <= in_handler_d;
            ie_q         <= ie_d;
            pie_q        <= pie_d;
            ovr_q        <= ovr_d;
        end
    end

    assign irq_req      = irq_req_q;
    assign irq_target   = irq_target_q;
    assign ret_redirect = ret_q;
    assign epc          = epc_q;
    assign irq_cause    = cause_q;
    assign in_handler   = in_handler_q;
    assign ie           = ie_q;
    assign irq_overrun  = ovr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Inputs change and outputs are sampled 1ns
// after each rising edge; expected values are hand-derived per scenario.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_interrupt;
`ifdef IRQ_CTRL_EXT_SRC_EN
    logic        ext_irq;
`endif
    logic        ie_we, ie_wdata;
    logic [31:0] current_pc;
    logic        irq_ack, mret, ovr_clr;
    logic        irq_req;
    logic [31:0] irq_target;
    logic        ret_redirect;
    logic [31:0] epc;
    logic [1:0]  irq_cause;
    logic        in_handler, ie, irq_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .timer_interrupt (timer_interrupt),
`ifdef IRQ_CTRL_EXT_SRC_EN
        .ext_irq         (ext_irq),
`endif
        .ie_we           (ie_we),
        .ie_wdata        (ie_wdata),
        .current_pc      (current_pc),
        .irq_ack         (irq_ack),
        .mret            (mret),
        .ovr_clr         (ovr_clr),
        .irq_req         (irq_req),
        .irq_target      (irq_target),
        .ret_redirect    (ret_redirect),
        .epc             (epc),
        .irq_cause       (irq_cause),
        .in_handler      (in_handler),
        .ie              (ie),
        .irq_overrun     (irq_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Timer high for exactly one edge; pending is visible after that edge.
    task automatic pulse_timer();
        timer_interrupt = 1'b1;
        step();
        timer_interrupt = 1'b0;
    endtask

    task automatic write_ie(input logic v);
        ie_we = 1'b1; ie_wdata = v;
        step();
        ie_we = 1'b0;
    endtask

    task automatic ack_at(input logic [31:0] pc);
        current_pc = pc; irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".irq_req"},    {31'b0, irq_req},      32'h0);
        chk({tag, ".target"},     irq_target,            32'h0);
        chk({tag, ".ret"},        {31'b0, ret_redirect}, 32'h0);
        chk({tag, ".epc"},        epc,                   32'h0);
        chk({tag, ".cause"},      {30'b0, irq_cause},    32'h0);
        chk({tag, ".in_handler"}, {31'b0, in_handler},   32'h0);
        chk({tag, ".ie"},         {31'b0, ie},           32'h0);
        chk({tag, ".overrun"},    {31'b0, irq_overrun},  32'h0);
    endtask

    initial begin
        reset = 1'b1; timer_interrupt = 1'b0;
`ifdef IRQ_CTRL_EXT_SRC_EN
        ext_irq = 1'b0;
`endif
        ie_we = 1'b0; ie_wdata = 1'b0; current_pc = 32'h0;
        irq_ack = 1'b0; mret = 1'b0; ovr_clr = 1'b0;
        step(); step();
        reset = 1'b0;
        chk_all_zero("reset");

        // Stray ack/mret in IDLE do nothing.
        irq_ack = 1'b1; mret = 1'b1;
        step();
        irq_ack = 1'b0; mret = 1'b0;
        chk("stray.in_handler", {31'b0, in_handler},   32'h0);
        chk("stray.ret",        {31'b0, ret_redirect}, 32'h0);

        // Basic entry: edge -> pending -> irq_req two edges later.
        write_ie(1'b1);
        chk("ie_set", {31'b0, ie}, 32'h1);
        pulse_timer();
        chk("A.req_n1", {31'b0, irq_req}, 32'h0);
        step();
        chk("A.req_n2", {31'b0, irq_req}, 32'h1);
        chk("A.vec",    irq_target,       32'h00000100);
        write_ie(1'b0);  // ie drop must not withdraw the request
        chk("A.req_hold", {31'b0, irq_req}, 32'h1);
        chk("A.vec_hold", irq_target,       32'h00000100);
        write_ie(1'b1);
        ack_at(32'h00000040);
        chk("A.req_off",    {31'b0, irq_req},    32'h0);
        chk("A.epc",        epc,                 32'h00000040);
        chk("A.cause",      {30'b0, irq_cause},  32'h1);
        chk("A.ie_off",     {31'b0, ie},         32'h0);
        chk("A.in_handler", {31'b0, in_handler}, 32'h1);
        chk("A.tgt_idle",   irq_target,          32'h0);
        do_mret();
        chk("A.ret",        {31'b0, ret_redirect}, 32'h1);
        chk("A.ret_tgt",    irq_target,            32'h00000040);
        chk("A.ret_inh",    {31'b0, in_handler},   32'h0);
        step();
        chk("A.ret_1cyc",   {31'b0, ret_redirect}, 32'h0);
        chk("A.ie_back",    {31'b0, ie},           32'h1);
        chk("A.cause_clr",  {30'b0, irq_cause},    32'h0);
        chk("A.tgt_zero",   irq_target,            32'h0);

        // Disabled: pending waits until ie is written to 1.
        write_ie(1'b0);
        pulse_timer();
        step(); step();
        chk("B.no_req", {31'b0, irq_req}, 32'h0);
        write_ie(1'b1);
        chk("B.req_w1", {31'b0, irq_req}, 32'h0);
        step();
        chk("B.req_w2", {31'b0, irq_req}, 32'h1);
        ack_at(32'h00000044);
        chk("B.epc", epc, 32'h00000044);
        do_mret();
        step();

        // Overrun, clear, and an edge coincident with ack.
        pulse_timer();
        step();
        chk("C.req", {31'b0, irq_req}, 32'h1);
        pulse_timer();
        chk("C.ovr", {31'b0, irq_overrun}, 32'h1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("C.ovr_clr", {31'b0, irq_overrun}, 32'h0);
        timer_interrupt = 1'b1;
        ack_at(32'h00000048);
        timer_interrupt = 1'b0;
        chk("C.in_handler", {31'b0, in_handler}, 32'h1);
        mret = 1'b1;
        irq_ack = 1'b1;  // ack outside REQ is ignored
        step();
        mret = 1'b0; irq_ack = 1'b0;
        chk("C.ret_tgt", irq_target, 32'h00000048);
        step();
        chk("C.idle_req", {31'b0, irq_req}, 32'h0);
        step();
        chk("C.reentry", {31'b0, irq_req}, 32'h1);
        chk("C.re_vec",  irq_target,       32'h00000100);
        ack_at(32'h0000004C);
        do_mret();
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

`ifdef IRQ_CTRL_EXT_SRC_EN
        // Simultaneous edges: timer first, external after return.
        timer_interrupt = 1'b1; ext_irq = 1'b1;
        step();
        timer_interrupt = 1'b0; ext_irq = 1'b0;
        step();
        chk("D.vec_t", irq_target, 32'h00000100);
        ack_at(32'h00000080);
        chk("D.cause_t", {30'b0, irq_cause}, 32'h1);
        do_mret();
        step(); step();
        chk("D.req_e", {31'b0, irq_req}, 32'h1);
        chk("D.vec_e", irq_target,       32'h00000180);
        ack_at(32'h00000084);
        chk("D.cause_e", {30'b0, irq_cause}, 32'h2);
        chk("D.epc_e",   epc,                32'h00000084);
        do_mret();
        chk("D.ret_tgt", irq_target, 32'h00000084);
        step();
`endif

        // Reset mid-handler discards pending work.
        pulse_timer();
        step();
        ack_at(32'h00000050);
        chk("E.in_handler", {31'b0, in_handler}, 32'h1);
        pulse_timer();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("E.reset");
        write_ie(1'b1);
        step(); step();
        chk("E.no_pending", {31'b0, irq_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter IRQ_VECTOR_TIMER, default 32'h00000100, handler address for timer interrupt SHALL be used.
REQ-002 Parameter IRQ_VECTOR_EXT, default 32'h00000180, handler address for external interrupt SHALL be used (only with IRQ_CTRL_EXT_SRC_EN).
REQ-003 Ports SHALL be, in order:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
timer_interrupt  in  1  timer done level from timer unit
ext_irq  in  1  external interrupt level (present only with IRQ_CTRL_EXT_SRC_EN)
ie_we  in  1  write strobe for global interrupt enable
ie_wdata  in  1  enable value written on ie_we
current_pc  in  32  PC of next instruction to execute, from fetch stage
irq_ack  in  1  fetch stage accepts redirect this cycle
mret  in  1  decoded return-from-interrupt, one-cycle pulse
ovr_clr  in  1  clears overrun flag
irq_req  out  1  redirect request to fetch stage
irq_target  out  32  redirect PC (vector on entry, epc on return)
ret_redirect  out  1  one-cycle return redirect pulse
epc  out  32  saved return PC
irq_cause  out  2  01 timer, 10 external, 00 none
in_handler  out  1  high while handler executes
ie  out  1  global interrupt enable
irq_overrun  out  1  sticky: edge lost while source already pending

Function
REQ-004 Each source SHALL be rising-edge detected against a one-cycle-delayed sample; an edge SHALL set that source's pending bit.
REQ-005 Edge on a source whose pending bit is already 1 SHALL set irq_overrun; irq_overrun SHALL clear only on ovr_clr (set wins if both same cycle).
REQ-006 FSM states SHALL be IDLE, REQ, HANDLER, RET.
REQ-007 IDLE -> REQ when ie=1 and any pending bit=1; selected source latched on transition; timer has priority over external.
REQ-008 In REQ, irq_req=1 and irq_target=vector of latched source, held stable until irq_ack; ie changes during REQ SHALL NOT withdraw the request.
REQ-009 On irq_ack in REQ: epc<=current_pc, irq_cause<=latched source, latched pending bit cleared, pie<=ie, ie<=0, next state HANDLER; irq_req low from next cycle.
REQ-010 Edge on the source being cleared in the ack cycle SHALL leave pending=1 (set wins over clear).
REQ-011 HANDLER: in_handler=1; pending bits keep collecting; no nesting; mret -> RET.
REQ-012 RET lasts exactly one cycle: ret_redirect=1, irq_target=epc, ie<=pie, irq_cause<=00, next IDLE.
REQ-013 irq_ack outside REQ and mret outside HANDLER SHALL be ignored.
REQ-014 ie_we SHALL update ie the next cycle in IDLE/HANDLER; in REQ ack-cycle and RET the FSM write wins.
REQ-015 irq_target SHALL be 0 when neither irq_req nor ret_redirect is high.
REQ-016 Earliest entry latency: edge at cycle N -> pending at N+1 -> irq_req at N+2.

Reset
REQ-017 reset SHALL force state IDLE and all outputs, pending bits, edge samples, pie to 0 (ie=0, epc=0) on next clock edge, including mid-REQ/HANDLER.

Configuration
REQ-018 Macro IRQ_CTRL_EXT_SRC_EN defined: ext_irq port, its pending bit and IRQ_VECTOR_EXT exist; cause 10 reachable.
REQ-019 Macro undefined: no ext_irq port; only timer source; irq_cause only 00/01; all other behaviour identical.

Verification
REQ-020 ie=1, timer pulse cycle 10 -> irq_req cycle 12, irq_target=32'h00000100; ack cycle 14 with current_pc=32'h00000040 -> epc=32'h00000040, cause=01, ie=0, in_handler=1.
REQ-021 In HANDLER, mret -> one-cycle ret_redirect with irq_target=32'h00000040, ie back to 1, state IDLE.
REQ-022 ie=0, timer pulse -> no irq_req; ie_we with 1 later -> irq_req two cycles after write.
REQ-023 Two timer edges before ack -> irq_overrun=1; ovr_clr -> 0; edge coincident with ack -> pending remains 1, re-entry after mret.
REQ-024 EXT_SRC_EN: timer and ext_irq edge same cycle -> timer serviced first (0x100), ext serviced after mret (0x180, cause 10).
REQ-025 reset asserted in HANDLER -> next cycle all outputs 0, state IDLE, earlier pending discarded.
